memory_arbiter: RTL



---
 rtl/memory_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Two-port arbiter (instruction fetch / load-store) that shares one synchronous single-port RAM.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin tie-break; default is fixed ls-over-if priority.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_a,
  output logic                  if_ack,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_a,
  input  logic [DATA_WIDTH-1:0] ls_din,
  input  logic                  ls_rw,
  output logic                  ls_ack,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_rw,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state, state_d;
  logic                  win_ls, win_ls_d;   // winner of the grant in flight
  logic                  rd, rd_d;           // grant in flight is a read
  logic [ADDR_WIDTH-1:0] ram_a_d;
  logic [DATA_WIDTH-1:0] ram_din_d, if_rdata_d, ls_rdata_d;
  logic                  ram_rw_d, if_ack_d, ls_ack_d, if_rvalid_d, ls_rvalid_d;
  logic                  pick_if;
  logic                  grant;

  assign grant = (state == IDLE) && (if_req || ls_req);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic last_ls, last_ls_d;

  // On a tie, fetch wins only if ls held the previous grant
  assign pick_if   = if_req && (!ls_req || last_ls);
  assign last_ls_d = grant ? !pick_if : last_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_ls <= 1'b1;
    else        last_ls <= last_ls_d;
  end
`else
  assign pick_if = if_req && !ls_req;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_d     = state;
    win_ls_d    = win_ls;
    rd_d        = rd;
    ram_a_d     = ram_a;
    ram_din_d   = ram_din;
    ram_rw_d    = 1'b0;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata;
    ls_rdata_d  = ls_rdata;
    case (state)
      IDLE: begin
        if (grant) begin
          win_ls_d  = !pick_if;
          ram_a_d   = pick_if ? if_a : ls_a;
          ram_din_d = ls_din;
          ram_rw_d  = !pick_if && ls_rw;
          rd_d      = pick_if || !ls_rw;
          if_ack_d  = pick_if;
          ls_ack_d  = !pick_if;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = rd ? RESP : IDLE;
      RESP: begin
        if (win_ls) begin
          ls_rdata_d  = ram_dout;
          ls_rvalid_d = 1'b1;
        end else begin
          if_rdata_d  = ram_dout;
          if_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Async clear of ram_rw also suppresses a write that has not reached its edge yet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_ls    <= 1'b0;
      rd        <= 1'b0;
      ram_a     <= '0;
      ram_din   <= '0;
      ram_rw    <= 1'b0;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      state     <= state_d;
      win_ls    <= win_ls_d;
      rd        <= rd_d;
      ram_a     <= ram_a_d;
      ram_din   <= ram_din_d;
      ram_rw    <= ram_rw_d;
      if_ack    <= if_ack_d;
      ls_ack    <= ls_ack_d;
      if_rvalid <= if_rvalid_d;
      ls_rvalid <= ls_rvalid_d;
      if_rdata  <= if_rdata_d;
      ls_rdata  <= ls_rdata_d;
    end
  end

endmodule
